// File: rtl/nand_10.sv
// Three-input NAND leaf cell: combinational q plus a one-cycle registered copy q_r.
// The single NAND term feeds both the output pin and the flop D input.
module nand_10 #(
    parameter logic RESET_Q = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic q,
    output logic q_r
);

    logic w_nand;
    logic r_q;

    // Built from the operator so any 0 input dominates an X on the others.
    assign w_nand = ~(a & b & c);
    assign q      = w_nand;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= RESET_Q;
        end else begin
            r_q <= w_nand;
        end
    end

    assign q_r = r_q;

endmodule

// File: tb/tb_nand_10.sv
// Directed bench for nand_10: combinational sweep, reset independence of q,
// registered latency, synchronous reset timing and dominant-zero X handling.
module tb_nand_10;

    logic clk;
    logic clk_en;
    logic rst_n;
    logic a;
    logic b;
    logic c;
    logic q;
    logic q_r;

    int checks;
    int errors;

    nand_10 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .q     (q),
        .q_r   (q_r)
    );

    // Clock is gated so the combinational sweep runs with clk held constant.
    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;

        // Exhaustive sweep of {c,b,a}, no clock, reset held asserted.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] code;
            code = 3'(i);
            {c, b, a} = code;
            #50;
            check($sformatf("sweep_q_%0d", i), q, (i == 7) ? 1'b0 : 1'b1);
        end
        {c, b, a} = 3'b000;
        #50;
        check("wrap_111_to_000_q", q, 1'b1);

        // Start the clock; reset value of q_r.
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("reset_q_r", q_r, 1'b1);

        // Reset independence of q: abc=111, rst_n toggled with clock running.
        @(negedge clk);
        a = 1'b1; b = 1'b1; c = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst_n = (k % 2 == 1) ? 1'b1 : 1'b0;
            #1;
            check($sformatf("rst_toggle_q_mid_%0d", k), q, 1'b0);
            @(posedge clk); #1;
            check($sformatf("rst_toggle_q_edge_%0d", k), q, 1'b0);
            check($sformatf("rst_toggle_q_r_%0d", k), q_r, rst_n ? 1'b0 : 1'b1);
        end

        // Registered path: 111 before edge N, 011 (a=0) before edge N+1.
        @(negedge clk);
        rst_n = 1'b1;
        a = 1'b1; b = 1'b1; c = 1'b1;
        #1;
        check("reg_q_111", q, 1'b0);
        @(posedge clk); #1;
        check("reg_q_r_edge_n", q_r, 1'b0);
        @(negedge clk);
        a = 1'b0;
        #1;
        check("reg_q_011_immediate", q, 1'b1);
        check("reg_q_r_latency", q_r, 1'b0);
        @(posedge clk); #1;
        check("reg_q_r_edge_n1", q_r, 1'b1);

        // Synchronous reset: assert between edges while q_r = 0.
        @(negedge clk);
        a = 1'b1;
        @(posedge clk); #1;
        check("sync_pre_q_r", q_r, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("sync_assert_hold_q_r", q_r, 1'b0);
        check("sync_assert_q", q, 1'b0);
        @(posedge clk); #1;
        check("sync_assert_edge_q_r", q_r, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("sync_release_hold_q_r", q_r, 1'b1);
        @(posedge clk); #1;
        check("sync_release_edge_q_r", q_r, 1'b0);

        // Dominant-zero X handling.
        clk_en = 1'b0;
        a = 1'b0; b = 1'bx; c = 1'bx;
        #50;
        check("x_dominant_zero_q", q, 1'b1);
        a = 1'b1; b = 1'b1; c = 1'bx;
        #50;
        // With a=b=1 the output is the inverse of whatever c resolves to (X stays X).
        check("x_propagate_q", q, ~c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
